// File: rtl/or1200_vlx_unpack_if.sv
// Byte fetch port between the VLX unpacker and the data-memory byte port.
// The unpacker is the master: it raises byte_req with a stable byte_addr and
// the memory answers with a single-cycle byte_ack carrying byte_dat.
interface or1200_vlx_unpack_if;
  logic        byte_req;
  logic [31:0] byte_addr;
  logic        byte_ack;
  logic [7:0]  byte_dat;

  modport master (
    output byte_req,
    output byte_addr,
    input  byte_ack,
    input  byte_dat
  );

  modport slave (
    input  byte_req,
    input  byte_addr,
    output byte_ack,
    output byte_dat
  );
endinterface

// File: rtl/or1200_vlx_unpack.sv
// VLX bit unpacker: fetches entropy-coded JPEG bytes, strips 0xFF/0x00
// stuffing, stops on markers and presents an MSB-first bit window to the
// Huffman decoder, which consumes 1..16 bits per cycle.
module or1200_vlx_unpack #(
  parameter int BUF_W  = 32,
  parameter int PEEK_W = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [31:0]                 start_addr_i,
  or1200_vlx_unpack_if.master         mem,
  output logic [PEEK_W-1:0]           bits_o,
  output logic [$clog2(BUF_W+1)-1:0]  avail_o,
  input  logic                        consume_i,
  input  logic [4:0]                  consume_n_i,
  output logic                        err_o,
  output logic                        marker_found_o,
  output logic [7:0]                  marker_code_o,
  output logic                        busy_o
);

  localparam int AW = $clog2(BUF_W + 1);
  // A fetch is only allowed while the appended byte still fits.
  localparam logic [AW-1:0] REQ_LIM = AW'(BUF_W - 8);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_FF_SEEN = 2'd2,
    S_MARKER  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [AW-1:0]     avail_q, avail_d;
  logic [31:0]       addr_q;
  logic              pend_q;
  logic              err_q;
  logic              marker_q;
  logic [7:0]        code_q;

  logic [AW-1:0]     n_ext;
  logic              cons_ok;
  logic              cons_bad;
  logic [AW-1:0]     n_eff;
  logic [AW-1:0]     avail_mid;
  logic              active;
  logic              req_new;
  logic              req;
  logic              ack_v;
  logic              app;
  logic [7:0]        app_byte;
  logic              mark_hit;
  logic [AW-1:0]     app_sh;
  logic [BUF_W-1:0]  app_vec;

  // Consume qualification, fetch request and ack qualification.
  always_comb begin
    n_ext     = AW'(consume_n_i);
    cons_ok   = consume_i && (n_ext <= avail_q);
    cons_bad  = consume_i && (n_ext > avail_q);
    n_eff     = cons_ok ? n_ext : '0;
    avail_mid = avail_q - n_eff;
    active    = (state_q == S_RUN) || (state_q == S_FF_SEEN);
    // Threshold looks at the fill level after this cycle's consume, so a
    // same-cycle ack can never push the buffer past BUF_W.
    req_new   = active && (avail_mid <= REQ_LIM);
    // Once raised, the request is held until acked even if the level rises.
    req       = pend_q || req_new;
    ack_v     = mem.byte_ack && req && !start_i;
  end

  assign mem.byte_req  = req;
  assign mem.byte_addr = addr_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: stuffing and marker detection on each accepted byte.
  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = S_RUN;
    end else if (ack_v) begin
      case (state_q)
        S_RUN: begin
          if (mem.byte_dat == 8'hFF) state_d = S_FF_SEEN;
        end
        S_FF_SEEN: begin
          if (mem.byte_dat == 8'h00)      state_d = S_RUN;
          else if (mem.byte_dat != 8'hFF) state_d = S_MARKER;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State outputs: what to append and whether a marker was hit.
  always_comb begin
    busy_o   = (state_q == S_RUN) || (state_q == S_FF_SEEN);
    app      = 1'b0;
    app_byte = mem.byte_dat;
    mark_hit = 1'b0;
    if (ack_v) begin
      case (state_q)
        S_RUN: begin
          app = (mem.byte_dat != 8'hFF);
        end
        S_FF_SEEN: begin
          // 0xFF 0x00 decodes to a literal 0xFF; 0xFF 0xFF is fill.
          app      = (mem.byte_dat == 8'h00);
          app_byte = 8'hFF;
          mark_hit = (mem.byte_dat != 8'h00) && (mem.byte_dat != 8'hFF);
        end
        default: ;
      endcase
    end
  end

  // Next buffer contents: left-aligned shift-out plus append behind the tail.
  always_comb begin
    app_sh  = REQ_LIM - avail_mid;
    app_vec = BUF_W'(app_byte) << app_sh;
    buf_d   = (buf_q << n_eff) | (app ? app_vec : '0);
    avail_d = avail_mid + (app ? AW'(8) : AW'(0));
  end

  // Buffer, fill level, fetch address and status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q    <= '0;
      avail_q  <= '0;
      addr_q   <= '0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      marker_q <= 1'b0;
      code_q   <= '0;
    end else if (start_i) begin
      buf_q    <= '0;
      avail_q  <= '0;
      addr_q   <= start_addr_i;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      marker_q <= 1'b0;
      code_q   <= '0;
    end else begin
      buf_q   <= buf_d;
      avail_q <= avail_d;
      pend_q  <= req && !ack_v;
      err_q   <= cons_bad;
      if (ack_v) addr_q <= addr_q + 32'd1;
      if (mark_hit) begin
        marker_q <= 1'b1;
        code_q   <= mem.byte_dat;
      end
    end
  end

  assign bits_o         = buf_q[BUF_W-1 -: PEEK_W];
  assign avail_o        = avail_q;
  assign err_o          = err_q;
  assign marker_found_o = marker_q;
  assign marker_code_o  = code_q;

endmodule

// File: tb/tb_or1200_vlx_unpack.sv
// Directed bench for the VLX bit unpacker.
module tb_or1200_vlx_unpack;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [31:0] start_addr_i;
  logic [15:0] bits_o;
  logic [5:0]  avail_o;
  logic        consume_i;
  logic [4:0]  consume_n_i;
  logic        err_o;
  logic        marker_found_o;
  logic [7:0]  marker_code_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  or1200_vlx_unpack_if mif ();

  or1200_vlx_unpack #(.BUF_W(32), .PEEK_W(16)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .start_addr_i   (start_addr_i),
    .mem            (mif),
    .bits_o         (bits_o),
    .avail_o        (avail_o),
    .consume_i      (consume_i),
    .consume_n_i    (consume_n_i),
    .err_o          (err_o),
    .marker_found_o (marker_found_o),
    .marker_code_o  (marker_code_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // One clock: inputs applied before the call are seen at this edge, then
  // all pulses are dropped and outputs settle before the caller samples.
  task automatic cyc();
    @(posedge clk_i);
    #1;
    start_i      = 1'b0;
    consume_i    = 1'b0;
    consume_n_i  = '0;
    mif.byte_ack = 1'b0;
    mif.byte_dat = '0;
    #1;
  endtask

  task automatic do_start(input logic [31:0] a);
    start_i      = 1'b1;
    start_addr_i = a;
    cyc();
  endtask

  task automatic do_consume(input logic [4:0] n);
    consume_i   = 1'b1;
    consume_n_i = n;
    cyc();
  endtask

  task automatic fetch(input logic [7:0] b);
    int n = 0;
    while (!mif.byte_req && n < 10) begin
      cyc();
      n++;
    end
    chk("req_seen", {31'd0, mif.byte_req}, 32'd1);
    mif.byte_ack = 1'b1;
    mif.byte_dat = b;
    cyc();
  endtask

  initial begin
    int cnt;
    rst_ni       = 1'b0;
    start_i      = 1'b0;
    start_addr_i = '0;
    consume_i    = 1'b0;
    consume_n_i  = '0;
    mif.byte_ack = 1'b0;
    mif.byte_dat = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req",   {31'd0, mif.byte_req}, 32'd0);
    chk("rst_addr",  mif.byte_addr, 32'd0);
    chk("rst_avail", {26'd0, avail_o}, 32'd0);
    chk("rst_bits",  {16'd0, bits_o}, 32'd0);
    chk("rst_busy",  {31'd0, busy_o}, 32'd0);
    chk("rst_mark",  {31'd0, marker_found_o}, 32'd0);
    chk("rst_err",   {31'd0, err_o}, 32'd0);
    rst_ni = 1'b1;
    cyc();

    // Plain bytes then a 4-bit consume.
    do_start(32'h100);
    chk("t1_busy", {31'd0, busy_o}, 32'd1);
    fetch(8'h12); fetch(8'h34); fetch(8'h56);
    chk("t1_avail24", {26'd0, avail_o}, 32'd24);
    chk("t1_bits0",   {16'd0, bits_o}, 32'h1234);
    do_consume(5'd4);
    chk("t1_bits",  {16'd0, bits_o}, 32'h2345);
    chk("t1_avail", {26'd0, avail_o}, 32'd20);
    chk("t1_addr",  mif.byte_addr, 32'h103);

    // Stuffed 0xFF 0x00 decodes to 0xFF.
    do_start(32'h200);
    fetch(8'hFF);
    chk("t2_ff_noapp", {26'd0, avail_o}, 32'd0);
    fetch(8'h00); fetch(8'hA5);
    chk("t2_bits",  {16'd0, bits_o}, 32'hFFA5);
    chk("t2_avail", {26'd0, avail_o}, 32'd16);
    chk("t2_addr",  mif.byte_addr, 32'h203);
    chk("t2_mark",  {31'd0, marker_found_o}, 32'd0);

    // Marker stops fetching; remaining bits still consumable.
    do_start(32'h300);
    fetch(8'h3C); fetch(8'hFF); fetch(8'hD9);
    chk("t3_avail", {26'd0, avail_o}, 32'd8);
    chk("t3_bits",  {16'd0, bits_o}, 32'h3C00);
    chk("t3_mark",  {31'd0, marker_found_o}, 32'd1);
    chk("t3_code",  {24'd0, marker_code_o}, 32'hD9);
    chk("t3_req",   {31'd0, mif.byte_req}, 32'd0);
    chk("t3_busy",  {31'd0, busy_o}, 32'd0);
    cyc();
    chk("t3_req_hold", {31'd0, mif.byte_req}, 32'd0);
    do_consume(5'd8);
    chk("t3_avail0", {26'd0, avail_o}, 32'd0);
    chk("t3_mark_sticky", {31'd0, marker_found_o}, 32'd1);

    // Ack every cycle until full, then refill under consume.
    do_start(32'h400);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (mif.byte_req) begin
        mif.byte_ack = 1'b1;
        mif.byte_dat = 8'(cnt + 1);
        cnt++;
      end
      cyc();
    end
    chk("t4_count",  cnt, 32'd4);
    chk("t4_full",   {26'd0, avail_o}, 32'd32);
    chk("t4_req0",   {31'd0, mif.byte_req}, 32'd0);
    chk("t4_bits",   {16'd0, bits_o}, 32'h0102);
    do_consume(5'd8);
    chk("t4_avail24", {26'd0, avail_o}, 32'd24);
    chk("t4_req1",    {31'd0, mif.byte_req}, 32'd1);
    chk("t4_bits2",   {16'd0, bits_o}, 32'h0203);
    fetch(8'h05);
    chk("t4_refull", {26'd0, avail_o}, 32'd32);
    chk("t4_req_off", {31'd0, mif.byte_req}, 32'd0);
    consume_i   = 1'b1;
    consume_n_i = 5'd16;
    #1;
    chk("t4_req_same", {31'd0, mif.byte_req}, 32'd1);
    mif.byte_ack = 1'b1;
    mif.byte_dat = 8'h06;
    cyc();
    chk("t4_avail_mix", {26'd0, avail_o}, 32'd24);
    chk("t4_bits_mix",  {16'd0, bits_o}, 32'h0405);

    // Over-consume is rejected with a one-cycle error pulse.
    do_start(32'h500);
    fetch(8'h5A);
    chk("t5_avail", {26'd0, avail_o}, 32'd8);
    do_consume(5'd12);
    chk("t5_err",   {31'd0, err_o}, 32'd1);
    chk("t5_avail_keep", {26'd0, avail_o}, 32'd8);
    chk("t5_bits_keep",  {16'd0, bits_o}, 32'h5A00);
    cyc();
    chk("t5_err_clr", {31'd0, err_o}, 32'd0);

    // Address wraps at 2^32.
    do_start(32'hFFFF_FFFF);
    fetch(8'h11);
    chk("wrap_addr", mif.byte_addr, 32'd0);
    chk("wrap_bits", {16'd0, bits_o}, 32'h1100);

    // Async reset kills an outstanding request at once.
    do_start(32'h600);
    chk("t6_req", {31'd0, mif.byte_req}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_req",  {31'd0, mif.byte_req}, 32'd0);
    chk("t6_rst_addr", mif.byte_addr, 32'd0);
    chk("t6_rst_busy", {31'd0, busy_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    cyc();

    // Start with a same-cycle ack drops the byte.
    do_start(32'h700);
    fetch(8'h42);
    start_i      = 1'b1;
    start_addr_i = 32'h800;
    mif.byte_ack = 1'b1;
    mif.byte_dat = 8'h99;
    cyc();
    chk("t6_avail", {26'd0, avail_o}, 32'd0);
    chk("t6_addr",  mif.byte_addr, 32'h800);
    chk("t6_bits",  {16'd0, bits_o}, 32'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

endmodule
